// File: rtl/tank_pkg.sv
// Shared tank-game definitions: direction codes, field limits, bullet states.
// Pure declarations plus a one-cell step helper; no timing or flow control.
package tank_pkg;

  localparam int COORD_W = 5;
  localparam int NUM_ENM = 4;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [COORD_W-1:0] FIELD_X_MAX   = 5'd16;
  localparam logic [COORD_W-1:0] FIELD_Y_MAX   = 5'd20;
  localparam logic [COORD_W-1:0] FIELD_OFF_POS = 5'd31;

  typedef enum logic [1:0] {
    BUL_IDLE = 2'b00,
    BUL_FLY  = 2'b01,
    BUL_EXPL = 2'b10
  } bul_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pos_t;

  // Caller guarantees the step stays inside the field.
  function automatic pos_t pos_step(pos_t p, logic [1:0] dir);
    pos_t n;
    n = p;
    case (dir)
      DIR_UP:    n.y = p.y - 5'd1;
      DIR_DOWN:  n.y = p.y + 5'd1;
      DIR_LEFT:  n.x = p.x - 5'd1;
      DIR_RIGHT: n.x = p.x + 5'd1;
      default:   n = p;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bul_hit_cmp.sv
// Flags every live enemy whose cell equals the bullet cell.
// Purely combinational, zero latency, no flow control.
module bul_hit_cmp
  import tank_pkg::*;
(
  input  pos_t               bul,
  input  pos_t               enm   [NUM_ENM],
  input  logic [NUM_ENM-1:0] alive,
  output logic [NUM_ENM-1:0] match
);

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ENM; i++) begin
      match[i] = alive[i] && (enm[i] == bul);
    end
  end

endmodule

// File: rtl/mybullet_app.sv
// Player bullet controller: launch on shoot edge, step per move_tick, hit detect, explosion hold.
// All outputs registered (one cycle after the deciding edge); no backpressure, move_tick paces motion.
module mybullet_app
  import tank_pkg::*;
#(
  parameter logic [COORD_W-1:0] X_MAX      = FIELD_X_MAX,
  parameter logic [COORD_W-1:0] Y_MAX      = FIELD_Y_MAX,
  parameter logic [COORD_W-1:0] OFF_POS    = FIELD_OFF_POS,
  parameter int unsigned        EXPL_TICKS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               move_tick,
  input  logic               tank_en,
  input  logic               bul_sht,
  input  logic [1:0]         tank_dir_in,
  input  logic [COORD_W-1:0] tank_x,
  input  logic [COORD_W-1:0] tank_y,
  input  logic [COORD_W-1:0] enm1_x,
  input  logic [COORD_W-1:0] enm1_y,
  input  logic [COORD_W-1:0] enm2_x,
  input  logic [COORD_W-1:0] enm2_y,
  input  logic [COORD_W-1:0] enm3_x,
  input  logic [COORD_W-1:0] enm3_y,
  input  logic [COORD_W-1:0] enm4_x,
  input  logic [COORD_W-1:0] enm4_y,
  input  logic [NUM_ENM-1:0] enm_alive,
  output logic [COORD_W-1:0] mybul_x,
  output logic [COORD_W-1:0] mybul_y,
  output logic [1:0]         mybul_dir,
  output logic               mybul_state_feedback,
  output logic               mybul_expl,
  output logic [NUM_ENM-1:0] enm_hit
);

  localparam int CNT_W = (EXPL_TICKS > 1) ? $clog2(EXPL_TICKS + 1) : 1;
  localparam logic [CNT_W-1:0] EXPL_LAST = CNT_W'(EXPL_TICKS);
  localparam pos_t POS_OFF = '{x: OFF_POS, y: OFF_POS};

  bul_state_t         state;
  bul_state_t         state_nxt;
  pos_t               pos;
  pos_t               pos_nxt;
  logic [1:0]         dir_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [NUM_ENM-1:0] hit_nxt;
  logic               fb_nxt;
  logic               expl_nxt;
  logic               sht_prev;
  logic               launch;
  logic               at_wall;
  logic               expl_done;
  logic [NUM_ENM-1:0] match;
  pos_t               enm [NUM_ENM];

  assign enm[0] = '{x: enm1_x, y: enm1_y};
  assign enm[1] = '{x: enm2_x, y: enm2_y};
  assign enm[2] = '{x: enm3_x, y: enm3_y};
  assign enm[3] = '{x: enm4_x, y: enm4_y};

  bul_hit_cmp u_hit_cmp (
    .bul   (pos),
    .enm   (enm),
    .alive (enm_alive),
    .match (match)
  );

  assign mybul_x = pos.x;
  assign mybul_y = pos.y;

  // sht_prev resets high so a button already held at reset release cannot fire.
  assign launch    = (state == BUL_IDLE) && bul_sht && !sht_prev && tank_en;
  assign cnt_inc   = cnt + CNT_W'(1);
  assign expl_done = move_tick && (cnt_inc >= EXPL_LAST);

  // Boundary is checked before stepping so 5-bit arithmetic never wraps.
  always_comb begin
    at_wall = 1'b0;
    case (mybul_dir)
      DIR_UP:    at_wall = (pos.y == '0);
      DIR_DOWN:  at_wall = (pos.y == Y_MAX);
      DIR_LEFT:  at_wall = (pos.x == '0);
      DIR_RIGHT: at_wall = (pos.x == X_MAX);
      default:   at_wall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BUL_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BUL_IDLE: if (launch) state_nxt = BUL_FLY;
      BUL_FLY: begin
        if (|match) begin
          state_nxt = BUL_EXPL;
        end else if (move_tick && at_wall) begin
          state_nxt = BUL_IDLE;
        end
      end
      BUL_EXPL: if (expl_done) state_nxt = BUL_IDLE;
      default:  state_nxt = BUL_IDLE;
    endcase
  end

  // Hit wins over a coincident move_tick: the position freezes on the hit cell.
  always_comb begin
    pos_nxt = pos;
    dir_nxt = mybul_dir;
    cnt_nxt = cnt;
    hit_nxt = '0;
    case (state)
      BUL_IDLE: begin
        if (launch) begin
          pos_nxt = '{x: tank_x, y: tank_y};
          dir_nxt = tank_dir_in;
        end else begin
          pos_nxt = POS_OFF;
        end
      end
      BUL_FLY: begin
        if (|match) begin
          hit_nxt = match;
          cnt_nxt = '0;
        end else if (move_tick) begin
          pos_nxt = at_wall ? POS_OFF : pos_step(pos, mybul_dir);
        end
      end
      BUL_EXPL: begin
        if (expl_done) begin
          pos_nxt = POS_OFF;
          cnt_nxt = '0;
        end else if (move_tick) begin
          cnt_nxt = cnt_inc;
        end
      end
      default: pos_nxt = POS_OFF;
    endcase
    fb_nxt   = (state_nxt != BUL_IDLE);
    expl_nxt = (state_nxt == BUL_EXPL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos                  <= POS_OFF;
      mybul_dir            <= DIR_UP;
      mybul_state_feedback <= 1'b0;
      mybul_expl           <= 1'b0;
      enm_hit              <= '0;
      cnt                  <= '0;
      sht_prev             <= 1'b1;
    end else begin
      pos                  <= pos_nxt;
      mybul_dir            <= dir_nxt;
      mybul_state_feedback <= fb_nxt;
      mybul_expl           <= expl_nxt;
      enm_hit              <= hit_nxt;
      cnt                  <= cnt_nxt;
      sht_prev             <= bul_sht;
    end
  end

endmodule

// File: tb/tb_mybullet_app.sv
// Scoreboard bench for mybullet_app: a bullet-level reference model predicts each
// output change with its cycle stamp; a monitor compares every observed change.
module tb_mybullet_app;

  localparam int XM = 16;
  localparam int YM = 20;
  localparam int ET = 2;
  localparam logic [17:0] RESET_TUPLE = {5'd31, 5'd31, 2'b00, 1'b0, 1'b0, 4'b0000};

  logic       clk = 1'b0;
  logic       rst;
  logic       move_tick, tank_en, bul_sht;
  logic [1:0] tank_dir_in;
  logic [4:0] tank_x, tank_y;
  logic [4:0] ex [4];
  logic [4:0] ey [4];
  logic [3:0] enm_alive;
  logic [4:0] mybul_x, mybul_y;
  logic [1:0] mybul_dir;
  logic       mybul_state_feedback, mybul_expl;
  logic [3:0] enm_hit;

  always #5 clk = ~clk;

  mybullet_app dut (
    .clk(clk), .rst(rst), .move_tick(move_tick), .tank_en(tank_en), .bul_sht(bul_sht),
    .tank_dir_in(tank_dir_in), .tank_x(tank_x), .tank_y(tank_y),
    .enm1_x(ex[0]), .enm1_y(ey[0]), .enm2_x(ex[1]), .enm2_y(ey[1]),
    .enm3_x(ex[2]), .enm3_y(ey[2]), .enm4_x(ex[3]), .enm4_y(ey[3]),
    .enm_alive(enm_alive), .mybul_x(mybul_x), .mybul_y(mybul_y), .mybul_dir(mybul_dir),
    .mybul_state_feedback(mybul_state_feedback), .mybul_expl(mybul_expl), .enm_hit(enm_hit)
  );

  typedef struct {
    int          cyc;
    logic [17:0] v;
  } exp_t;

  exp_t exp_q [$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a bullet that is flying, exploding (with ticks left) or absent.
  bit          m_fly, m_expl, m_prev;
  int          m_x, m_y, m_dir, m_left;
  logic [3:0]  m_hit;
  logic [17:0] m_last;

  function automatic logic [17:0] dut_tuple();
    return {mybul_x, mybul_y, mybul_dir, mybul_state_feedback, mybul_expl, enm_hit};
  endfunction

  function automatic logic [17:0] model_out();
    logic [4:0] xo, yo;
    xo = (m_fly || m_expl) ? 5'(m_x) : 5'd31;
    yo = (m_fly || m_expl) ? 5'(m_y) : 5'd31;
    return {xo, yo, 2'(m_dir), (m_fly || m_expl), m_expl, m_hit};
  endfunction

  task automatic model_reset();
    m_fly = 0; m_expl = 0; m_prev = 1;
    m_x = 31; m_y = 31; m_dir = 0; m_left = 0; m_hit = 4'b0;
  endtask

  task automatic model_push();
    logic [17:0] t;
    t = model_out();
    if (t !== m_last) begin
      exp_q.push_back('{cyc + 1, t});
      m_last = t;
    end
  endtask

  // Predicts the effect of the upcoming clock edge given the inputs now applied.
  task automatic model_step();
    logic [3:0] hv;
    int dx, dy, nx, ny;
    if (rst) begin
      model_reset();
      model_push();
      return;
    end
    hv = 4'b0;
    if (m_fly) begin
      for (int i = 0; i < 4; i++) begin
        if (enm_alive[i] && int'(ex[i]) == m_x && int'(ey[i]) == m_y) hv[i] = 1'b1;
      end
    end
    if (!m_fly && !m_expl) begin
      if (bul_sht && !m_prev && tank_en) begin
        m_fly = 1; m_x = int'(tank_x); m_y = int'(tank_y); m_dir = int'(tank_dir_in);
      end
    end else if (m_fly) begin
      if (hv != 4'b0) begin
        m_fly = 0; m_expl = 1; m_left = ET;
      end else if (move_tick) begin
        dx = (m_dir == 2) ? -1 : (m_dir == 3) ? 1 : 0;
        dy = (m_dir == 0) ? -1 : (m_dir == 1) ? 1 : 0;
        nx = m_x + dx;
        ny = m_y + dy;
        if (nx < 0 || nx > XM || ny < 0 || ny > YM) m_fly = 0;
        else begin m_x = nx; m_y = ny; end
      end
    end else if (move_tick) begin
      m_left--;
      if (m_left == 0) m_expl = 0;
    end
    m_prev = bul_sht;
    m_hit  = hv;
    model_push();
  endtask

  // Monitor: every change of the output tuple must match the next prediction and its cycle.
  initial begin
    logic [17:0] last, cur;
    exp_t e;
    last = RESET_TUPLE;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      cur = dut_tuple();
      if (cur !== last) begin
        last = cur;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL out_unexpected cyc=%0d got=%h required=none", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.v !== cur) begin
            bad++;
            $display("FAIL out_seq cyc=%0d got=%h required=%h at cyc=%0d", cyc, cur, e.v, e.cyc);
          end
        end
      end
    end
  end

  task automatic run(input bit tk);
    move_tick = tk;
    model_step();
    @(negedge clk);
  endtask

  task automatic ticks(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      run(1'b1);
      repeat (gap) run(1'b0);
    end
  endtask

  task automatic shoot_pulse();
    bul_sht = 1'b1; run(1'b0);
    bul_sht = 1'b0; run(1'b0);
  endtask

  task automatic set_tank(input int x, input int y, input int d);
    tank_x = 5'(x); tank_y = 5'(y); tank_dir_in = 2'(d);
  endtask

  task automatic check_reset(input string name);
    total++;
    if (dut_tuple() !== RESET_TUPLE) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, dut_tuple(), RESET_TUPLE);
    end
  endtask

  initial begin
    rst = 1'b1; move_tick = 1'b0; tank_en = 1'b1; bul_sht = 1'b0;
    set_tank(0, 0, 0);
    for (int i = 0; i < 4; i++) begin ex[i] = 5'd0; ey[i] = 5'd0; end
    enm_alive = 4'b0;
    model_reset();
    m_last = RESET_TUPLE;
    @(negedge clk);
    @(negedge clk);
    check_reset("reset_init");
    rst = 1'b0;
    run(1'b0);

    // Launch upward and retire off the top edge without an explosion.
    set_tank(7, 7, 0);
    shoot_pulse();
    ticks(9, 2);

    // Hit enemy 2 moving right, then hold the explosion for two ticks.
    set_tank(3, 10, 3);
    ex[1] = 5'd6; ey[1] = 5'd10; enm_alive = 4'b0010;
    shoot_pulse();
    ticks(6, 1);

    // Same path with enemy 2 dead; tank_en drop mid-flight must not abort.
    enm_alive = 4'b0000;
    shoot_pulse();
    tank_en = 1'b0;
    ticks(15, 1);
    tank_en = 1'b1;

    // Held shoot does not refire; a one-cycle release re-arms it.
    set_tank(8, 10, 1);
    bul_sht = 1'b1; run(1'b0);
    ticks(12, 0);
    repeat (10) run(1'b0);
    bul_sht = 1'b0; run(1'b0);
    bul_sht = 1'b1; run(1'b0);
    ticks(12, 0);
    bul_sht = 1'b0; run(1'b0);

    // Hit and move_tick in the same cycle.
    set_tank(3, 10, 3);
    ex[0] = 5'd4; ey[0] = 5'd10; enm_alive = 4'b0001;
    shoot_pulse();
    run(1'b1);
    run(1'b1);
    ticks(3, 1);

    // Launch on the right edge retires on the first tick.
    enm_alive = 4'b0000;
    set_tank(16, 5, 3);
    shoot_pulse();
    run(1'b1);
    run(1'b0);

    // Disabled tank cannot launch.
    tank_en = 1'b0;
    shoot_pulse();
    ticks(2, 0);
    tank_en = 1'b1;

    // Asynchronous reset while flying at (4,4); held shoot must not launch afterwards.
    set_tank(4, 6, 0);
    bul_sht = 1'b1; run(1'b0);
    ticks(2, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    model_push();
    #1;
    check_reset("reset_async");
    @(negedge clk);
    run(1'b0);
    run(1'b0);
    rst = 1'b0;
    repeat (5) run(1'b0);
    bul_sht = 1'b0; run(1'b0);

    // Randomized traffic with enemies often placed on the tank's row or column.
    for (int n = 0; n < 2000; n++) begin
      if (n % 40 == 0) begin
        set_tank($urandom_range(0, XM), $urandom_range(0, YM), $urandom_range(0, 3));
        for (int i = 0; i < 4; i++) begin
          ex[i] = ($urandom_range(0, 1) == 1) ? tank_x : 5'($urandom_range(0, XM));
          ey[i] = ($urandom_range(0, 1) == 1) ? tank_y : 5'($urandom_range(0, YM));
        end
        enm_alive = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 7) == 0) bul_sht = ~bul_sht;
      tank_en = ($urandom_range(0, 9) != 0);
      run($urandom_range(0, 2) == 0);
    end

    bul_sht = 1'b0;
    repeat (40) run(1'b1);
    repeat (3) run(1'b0);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
